// File: rtl/veririsc_pkg.sv
// veririsc_pkg: shared VeriRISC opcode, phase and control-state encodings.
// The opcode constants are also used by the ALU.
package veririsc_pkg;
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    localparam logic [1:0] CTL_RUN    = 2'd0;
    localparam logic [1:0] CTL_HALTED = 2'd1;
    localparam logic [1:0] CTL_PAUSE  = 2'd2;

    typedef struct packed {
        logic sel;
        logic rd;
        logic ld_ir;
        logic inc_pc;
        logic ld_pc;
        logic halt;
        logic data_e;
        logic ld_ac;
        logic wr;
    } strobes_t;
endpackage

// File: rtl/veririsc_ctrl_decode.sv
// veririsc_ctrl_decode: combinational strobe decode from phase, control state,
// opcode and the ALU zero flag.
module veririsc_ctrl_decode
    import veririsc_pkg::*;
(
    input  logic [2:0] phase,
    input  logic [1:0] ctl,
    input  logic [2:0] opcode,
    input  logic       zero,
    output strobes_t   strobes
);
    logic run;
    logic aluop;
    logic late;

    assign run   = ctl == CTL_RUN;
    assign aluop = opcode inside {OP_ADD, OP_AND, OP_XOR, OP_LDA};
    assign late  = run && phase >= PH_ALU_OP;

    always_comb begin
        strobes        = '0;
        strobes.sel    = (run && phase <= PH_IDLE) || ctl == CTL_PAUSE;
        strobes.rd     = run && ((phase >= PH_INST_FETCH && phase <= PH_IDLE) || (phase >= PH_OP_FETCH && aluop));
        strobes.ld_ir  = run && (phase == PH_INST_LOAD || phase == PH_IDLE);
        strobes.inc_pc = run && (phase == PH_OP_ADDR || (phase == PH_ALU_OP && opcode == OP_SKZ && zero));
        strobes.halt   = ctl == CTL_HALTED || (run && phase == PH_OP_ADDR && opcode == OP_HLT);
        strobes.ld_pc  = late && opcode == OP_JMP;
        strobes.data_e = late && opcode == OP_STO;
        strobes.ld_ac  = run && phase == PH_STORE && aluop;
        strobes.wr     = run && phase == PH_STORE && opcode == OP_STO;
    end
endmodule

// File: rtl/veririsc_ctrl.sv
// veririsc_ctrl: VeriRISC eight-phase instruction sequencer with halt/resume.
// Define VERIRISC_CTRL_STEP_EN to add single-instruction stepping (PAUSE state).
module veririsc_ctrl
    import veririsc_pkg::*;
#(
    parameter int OPCODE_WIDTH = 3,
    parameter int PHASE_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    resume,
`ifdef VERIRISC_CTRL_STEP_EN
    input  logic                    step_mode,
    input  logic                    step,
`endif
    output logic                    sel,
    output logic                    rd,
    output logic                    ld_ir,
    output logic                    inc_pc,
    output logic                    ld_pc,
    output logic                    halt,
    output logic                    data_e,
    output logic                    ld_ac,
    output logic                    wr,
    output logic [PHASE_WIDTH-1:0]  phase
);
    logic [1:0]             ctl;
    logic [1:0]             ctl_nxt;
    logic [PHASE_WIDTH-1:0] phase_nxt;
    strobes_t               strobes;

    always_comb begin
        ctl_nxt   = ctl;
        phase_nxt = phase;
        if (ctl == CTL_RUN) begin
            // HLT freezes the phase at OP_ADDR; the PC has already been bumped
            if (phase == PH_OP_ADDR && opcode == OP_HLT)
                ctl_nxt = CTL_HALTED;
            else
                phase_nxt = phase + 1'b1;
`ifdef VERIRISC_CTRL_STEP_EN
            if (phase == PH_STORE && step_mode)
                ctl_nxt = CTL_PAUSE;
`endif
        end else if (ctl == CTL_HALTED && resume) begin
            ctl_nxt   = CTL_RUN;
            phase_nxt = PH_INST_ADDR;
        end
`ifdef VERIRISC_CTRL_STEP_EN
        else if (ctl == CTL_PAUSE && (step || !step_mode))
            ctl_nxt = CTL_RUN;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl   <= CTL_RUN;
            phase <= PH_INST_ADDR;
        end else begin
            ctl   <= ctl_nxt;
            phase <= phase_nxt;
        end
    end

    veririsc_ctrl_decode u_decode (
        .phase   (phase),
        .ctl     (ctl),
        .opcode  (opcode),
        .zero    (zero),
        .strobes (strobes)
    );

    assign {sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr} = strobes;
endmodule

// File: doc/veririsc_ctrl.md
# veririsc_ctrl

Instruction sequencer for the VeriRISC CPU. An eight-phase state machine steps every instruction through fetch, decode, operand fetch, execute and store. In each phase it drives the strobes for the PC, instruction register, memory, accumulator and ALU datapath. It decodes the 3-bit opcode also presented to the ALU, uses the ALU `a_is_zero` flag for SKZ, and owns the halt/resume condition.

## Interface
- `OPCODE_WIDTH`, 3, opcode width; only 3 is supported.
- `PHASE_WIDTH`, 3, phase counter width; only 3 is supported.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in OPCODE_WIDTH: instruction register opcode field; stable from phase 3 through phase 7.
- `zero` in 1: ALU `a_is_zero` (accumulator equals 0).
- `resume` in 1: leaves HALTED; sampled only in HALTED.
- `sel` out 1: address mux; 1 selects PC, 0 selects the IR operand.
- `rd` out 1: memory read enable.
- `ld_ir` out 1: instruction register load.
- `inc_pc` out 1: PC increment.
- `ld_pc` out 1: PC load from the IR operand (jump).
- `halt` out 1: CPU halted.
- `data_e` out 1: accumulator drives the data bus.
- `ld_ac` out 1: accumulator load from the ALU result.
- `wr` out 1: memory write enable.
- `phase` out PHASE_WIDTH: current phase, for debug.

## Operation
- Control state `ctl` is RUN or HALTED. Phase register runs 0..7 and wraps 7→0 in RUN.
- Phases: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE.
- Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- ALUOP means ADD, AND, XOR or LDA.
- Strobes are decoded combinationally from `phase`, `ctl`, `opcode` and `zero`. Any strobe not listed for a phase is 0.
  - Phase 0: `sel`.
  - Phase 1: `sel`, `rd`.
  - Phase 2: `sel`, `rd`, `ld_ir`.
  - Phase 3: `sel`, `rd`, `ld_ir`.
  - Phase 4: `inc_pc`; `halt` if HLT.
  - Phase 5: `rd` if ALUOP.
  - Phase 6: `rd` if ALUOP; `inc_pc` if SKZ and `zero`; `ld_pc` if JMP; `data_e` if STO.
  - Phase 7: `rd` and `ld_ac` if ALUOP; `ld_pc` if JMP; `wr` and `data_e` if STO.
- HLT: at the phase 4 edge, `ctl` goes to HALTED and `phase` holds at 4. The PC has already advanced past the HLT.
- HALTED outputs: `halt`=1, all other strobes 0, `phase`=4.
- `resume`=1 in HALTED: next edge sets `ctl`=RUN and `phase`=0, so the next instruction is fetched. `resume` in RUN has no effect.
- SKZ with `zero`=0 and undefined opcode bits: no extra strobes; the instruction completes all 8 phases.

## Timing
- Reset (async, takes effect immediately, including mid-instruction): `ctl`=RUN, `phase`=0, `sel`=1, all other outputs 0.
- First rising edge after `rst_n` deasserts: `phase`=1.
- Each instruction takes exactly 8 cycles in RUN.
- Halt latency: `halt` rises combinationally in phase 4 of a HLT instruction and stays high from then until the `resume` edge.
- Resume-to-fetch: `phase`=0 in the cycle after `resume` is sampled.
- `zero` is consumed in phase 6 only. `opcode` is ignored in phases 0–3.

## Configuration
- `VERIRISC_CTRL_STEP_EN`
  - Defined: adds inputs `step_mode` and `step`, plus state PAUSE.
  - With `step_mode`=1, RUN at phase 7 goes to PAUSE, with `phase` held at 0 and all strobes 0 except `sel`.
  - `step`=1 in PAUSE returns to RUN at phase 0 on the next edge, so exactly one instruction executes per `step` pulse.
  - `step_mode`=0 in PAUSE releases on the next edge.
  - HALTED has priority over PAUSE.
- Undefined: ports and PAUSE are absent; free-running behaviour as above.

## Structure
- Shared package `veririsc_pkg` holds:
  - opcode localparams (HLT..JMP), also used by the ALU;
  - phase encoding localparams (INST_ADDR..STORE);
  - `ctl` state encoding.
- One sub-module, `veririsc_ctrl_decode`: purely combinational strobe decode from `phase`, `ctl`, `opcode` and `zero`.
- The top module keeps only the phase counter and the `ctl` FSM.

## Test plan
- Reset mid-instruction at phase 5: outputs go to `sel`=1, all others 0, `phase`=0 without waiting for a clock; `phase`=1 after the first edge.
- ADD (010) with `zero`=0:
  - phase 5: `rd`=1;
  - phase 7: `rd`=1, `ld_ac`=1;
  - no `wr`, `ld_pc` or `data_e` in any phase.
- SKZ (001):
  - `zero`=1: `inc_pc` high in phases 4 and 6;
  - `zero`=0: `inc_pc` high in phase 4 only.
- STO (110): `data_e` high in phases 6 and 7; `wr` high only in phase 7. JMP (111): `ld_pc` high in phases 6 and 7.
- HLT (000):
  - `halt` rises in phase 4 and `phase` stays 4 for 20 cycles with all other strobes 0;
  - a `resume` pulse gives `phase`=0 on the next cycle with `halt`=0;
  - `resume` asserted during RUN changes nothing.
- With `VERIRISC_CTRL_STEP_EN` and `step_mode`=1: the controller stalls at `phase`=0 after each instruction; each `step` pulse yields exactly 8 RUN cycles.
